// File: rtl/operand_fetch.sv
// operand_fetch
//   Register-file read stage feeding the ALU. Two bypassed read ports resolve
//   source operands. Operand 2 is either register 2 or the extended immediate.
//   The resolved operands go through one output register stage that honours a
//   downstream stall.
//
//   Ports
//     clock, resetN                   clock, async active-low reset
//     inValid, stall                  request valid / downstream back-pressure
//     readRegister1, readRegister2    source register IDs
//     aluSRC                          1: operand 2 = immediate, 0: register 2
//     immediate, immSigned            raw immediate, sign(1)/zero(0) extend
//     regWriteFlag, writeRegister,
//     writeData                       write-back port
//     readData1, readData2            ALU operands (registered)
//     storeData                       register-2 value for stores (registered)
//     outValid                        outputs carry a valid request

// One read port. A write to the same ID in this cycle is forwarded, so
// the port returns the value the register holds after the edge.
module operand_fetch_read_port #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int IDX_WIDTH  = 5
) (
    input  logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs,
    input  logic [4:0]                           readId,
    input  logic                                 wrEn,
    input  logic [4:0]                           writeRegister,
    input  logic [DATA_WIDTH-1:0]                writeData,
    output logic [DATA_WIDTH-1:0]                readData
);

    logic inRange;
    logic bypassHit;

    // ID 31 is hard-wired zero. IDs beyond the file size also read as zero.
    assign inRange   = (readId != 5'd31) && (32'(readId) < 32'(REG_COUNT));
    // wrEn already excludes ID 31 and out-of-range IDs.
    assign bypassHit = wrEn && (writeRegister == readId);

    always_comb begin
        readData = '0;
        if (bypassHit)
            readData = writeData;
        else if (inRange)
            readData = regs[readId[IDX_WIDTH-1:0]];
    end

endmodule

module operand_fetch #(
    parameter int DATA_WIDTH = 32,
    parameter int REG_COUNT  = 32,
    parameter int IMM_WIDTH  = 12
) (
    input  logic                  clock,
    input  logic                  resetN,
    input  logic                  inValid,
    input  logic                  stall,
    input  logic [4:0]            readRegister1,
    input  logic [4:0]            readRegister2,
    input  logic                  aluSRC,
    input  logic [IMM_WIDTH-1:0]  immediate,
    input  logic                  immSigned,
    input  logic                  regWriteFlag,
    input  logic [4:0]            writeRegister,
    input  logic [DATA_WIDTH-1:0] writeData,
    output logic [DATA_WIDTH-1:0] readData1,
    output logic [DATA_WIDTH-1:0] readData2,
    output logic [DATA_WIDTH-1:0] storeData,
    output logic                  outValid
);

    localparam int NUM_PORTS = 2;
    localparam int IDX_WIDTH = (REG_COUNT > 1) ? $clog2(REG_COUNT) : 1;

    typedef struct packed {
        logic [DATA_WIDTH-1:0] op1;
        logic [DATA_WIDTH-1:0] op2;
        logic [DATA_WIDTH-1:0] store;
    } operandBundle;

    logic [REG_COUNT-1:0][DATA_WIDTH-1:0] regs;
    logic [NUM_PORTS-1:0][4:0]            readIds;
    logic [NUM_PORTS-1:0][DATA_WIDTH-1:0] portData;
    logic                                 wrEn;
    logic [DATA_WIDTH-1:0]                immExt;
    operandBundle                         resolved;
    operandBundle                         held;

    // Writes proceed whatever stall and inValid are doing. The write-back
    // path is independent of the fetch pipeline.
    assign wrEn = regWriteFlag && (writeRegister != 5'd31) &&
                  (32'(writeRegister) < 32'(REG_COUNT));

    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN)
            regs <= '0;
        else if (wrEn)
            regs[writeRegister[IDX_WIDTH-1:0]] <= writeData;
    end

    assign readIds = {readRegister2, readRegister1};

    for (genvar p = 0; p < NUM_PORTS; p++) begin : gPort
        operand_fetch_read_port #(
            .DATA_WIDTH (DATA_WIDTH),
            .REG_COUNT  (REG_COUNT),
            .IDX_WIDTH  (IDX_WIDTH)
        ) uPort (
            .regs          (regs),
            .readId        (readIds[p]),
            .wrEn          (wrEn),
            .writeRegister (writeRegister),
            .writeData     (writeData),
            .readData      (portData[p])
        );
    end

    // The top bit of the immediate drives the extension only when immSigned is set.
    assign immExt = {{(DATA_WIDTH-IMM_WIDTH){immSigned & immediate[IMM_WIDTH-1]}},
                     immediate};

    always_comb begin
        resolved       = '0;
        resolved.op1   = portData[0];
        resolved.op2   = aluSRC ? immExt : portData[1];
        resolved.store = portData[1];
    end

    // Output stage. A stalled request is re-resolved on every edge, so the
    // first edge with stall low picks up any writes that landed during the
    // stall. The operands keep their old value on an idle cycle. outValid
    // drops on that cycle.
    always_ff @(posedge clock or negedge resetN) begin
        if (!resetN) begin
            held     <= '0;
            outValid <= 1'b0;
        end else if (!stall) begin
            outValid <= inValid;
            if (inValid)
                held <= resolved;
        end
    end

    assign readData1 = held.op1;
    assign readData2 = held.op2;
    assign storeData = held.store;

endmodule

// File: tb/tb_operand_fetch.sv
module tb_operand_fetch;

    logic        clock = 1'b0;
    logic        resetN;
    logic        inValid;
    logic        stall;
    logic [4:0]  readRegister1;
    logic [4:0]  readRegister2;
    logic        aluSRC;
    logic [11:0] immediate;
    logic        immSigned;
    logic        regWriteFlag;
    logic [4:0]  writeRegister;
    logic [31:0] writeData;
    logic [31:0] readData1;
    logic [31:0] readData2;
    logic [31:0] storeData;
    logic        outValid;

    int tests = 0;
    int failures = 0;

    operand_fetch #(.DATA_WIDTH(32), .REG_COUNT(32), .IMM_WIDTH(12)) dut (
        .clock         (clock),
        .resetN        (resetN),
        .inValid       (inValid),
        .stall         (stall),
        .readRegister1 (readRegister1),
        .readRegister2 (readRegister2),
        .aluSRC        (aluSRC),
        .immediate     (immediate),
        .immSigned     (immSigned),
        .regWriteFlag  (regWriteFlag),
        .writeRegister (writeRegister),
        .writeData     (writeData),
        .readData1     (readData1),
        .readData2     (readData2),
        .storeData     (storeData),
        .outValid      (outValid)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic chkAll(input string tag, input logic [31:0] r1, input logic [31:0] r2,
                          input logic [31:0] st, input logic v);
        chk({tag, ".rd1"}, readData1, r1);
        chk({tag, ".rd2"}, readData2, r2);
        chk({tag, ".store"}, storeData, st);
        chk({tag, ".valid"}, {31'b0, outValid}, {31'b0, v});
    endtask

    // Advance one rising edge and settle just after it.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic req(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic src, input logic [11:0] imm, input logic sgn);
        inValid = v; readRegister1 = r1; readRegister2 = r2;
        aluSRC = src; immediate = imm; immSigned = sgn;
    endtask

    task automatic wr(input logic en, input logic [4:0] id, input logic [31:0] d);
        regWriteFlag = en; writeRegister = id; writeData = d;
    endtask

    initial begin
        resetN = 1'b0; stall = 1'b0;
        req(1'b0, 5'd0, 5'd0, 1'b0, 12'h0, 1'b0);
        wr(1'b0, 5'd0, 32'd0);
        #3;
        chkAll("reset", 32'd0, 32'd0, 32'd0, 1'b0);
        #9 resetN = 1'b1;

        // Fresh file reads zero, first edge after reset accepted.
        req(1'b1, 5'd1, 5'd2, 1'b0, 12'h0, 1'b0);
        tick();
        chkAll("rd_x1x2", 32'd0, 32'd0, 32'd0, 1'b1);

        // Same-cycle write/read of X3 is forwarded.
        req(1'b1, 5'd3, 5'd3, 1'b0, 12'h0, 1'b0);
        wr(1'b1, 5'd3, 32'd15);
        tick();
        chkAll("bypass_x3", 32'd15, 32'd15, 32'd15, 1'b1);

        // Subsequent read returns the stored value.
        wr(1'b0, 5'd0, 32'd0);
        tick();
        chkAll("stored_x3", 32'd15, 32'd15, 32'd15, 1'b1);

        // Idle cycle: write X2=10 still happens, operands hold, valid drops.
        req(1'b0, 5'd0, 5'd0, 1'b0, 12'h0, 1'b0);
        wr(1'b1, 5'd2, 32'd10);
        tick();
        chkAll("idle_hold", 32'd15, 32'd15, 32'd15, 1'b0);

        // Write to X31 discarded, also not forwarded.
        req(1'b1, 5'd31, 5'd31, 1'b0, 12'h0, 1'b0);
        wr(1'b1, 5'd31, 32'd99);
        tick();
        chkAll("x31_same", 32'd0, 32'd0, 32'd0, 1'b1);
        wr(1'b0, 5'd0, 32'd0);
        tick();
        chkAll("x31_after", 32'd0, 32'd0, 32'd0, 1'b1);

        // Immediate extension; storeData always carries X2.
        req(1'b1, 5'd3, 5'd2, 1'b1, 12'hFFF, 1'b1);
        tick();
        chkAll("imm_sext", 32'd15, 32'hFFFF_FFFF, 32'd10, 1'b1);
        req(1'b1, 5'd3, 5'd2, 1'b1, 12'hFFF, 1'b0);
        tick();
        chkAll("imm_zext", 32'd15, 32'h0000_0FFF, 32'd10, 1'b1);
        req(1'b1, 5'd2, 5'd2, 1'b1, 12'h800, 1'b1);
        tick();
        chkAll("imm_min", 32'd10, 32'hFFFF_F800, 32'd10, 1'b1);
        req(1'b1, 5'd2, 5'd2, 1'b1, 12'h7FF, 1'b1);
        tick();
        chkAll("imm_max", 32'd10, 32'h0000_07FF, 32'd10, 1'b1);

        // Stall 3 cycles on a read of X4 while X4=5 is written.
        stall = 1'b1;
        req(1'b1, 5'd4, 5'd4, 1'b0, 12'h0, 1'b0);
        wr(1'b1, 5'd4, 32'd5);
        tick();
        chkAll("stall1", 32'd10, 32'h0000_07FF, 32'd10, 1'b1);
        wr(1'b0, 5'd0, 32'd0);
        tick();
        chkAll("stall2", 32'd10, 32'h0000_07FF, 32'd10, 1'b1);
        tick();
        chkAll("stall3", 32'd10, 32'h0000_07FF, 32'd10, 1'b1);
        stall = 1'b0;
        tick();
        chkAll("unstall_x4", 32'd5, 32'd5, 32'd5, 1'b1);

        // Reset mid-stall clears outputs at once, without a clock edge.
        stall = 1'b1;
        req(1'b1, 5'd3, 5'd2, 1'b0, 12'h0, 1'b0);
        #2 resetN = 1'b0;
        #1;
        chkAll("async_rst", 32'd0, 32'd0, 32'd0, 1'b0);
        resetN = 1'b1;
        // Held request discarded: still stalled, so nothing loads.
        tick();
        chkAll("rst_stalled", 32'd0, 32'd0, 32'd0, 1'b0);
        stall = 1'b0;
        tick();
        chkAll("rst_x3x2", 32'd0, 32'd0, 32'd0, 1'b1);
        req(1'b1, 5'd4, 5'd1, 1'b0, 12'h0, 1'b0);
        tick();
        chkAll("rst_x4x1", 32'd0, 32'd0, 32'd0, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
